// File: rtl/multicycle_main_fsm_pkg.sv
// multicycle_main_fsm_pkg: state encodings, opcodes, datapath select codes and the control word
package multicycle_main_fsm_pkg;
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9
   } state_e;
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] SRCB_B    = 2'b00;
   localparam logic [1:0] SRCB_4    = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_IMM2 = 2'b11;
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_source;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       instr_done;
      logic       illegal_op;
   } ctrl_t;
   function automatic logic is_legal_op(input logic [5:0] op);
      return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J};
   endfunction
endpackage

// File: rtl/multicycle_main_fsm_if.sv
// multicycle_main_fsm_if: opcode/handshake inputs and datapath control outputs of the main FSM
interface multicycle_main_fsm_if;
   logic [5:0] op;
   logic       mem_ready;
   logic       PCWrite;
   logic       PCWriteCond;
   logic [1:0] PCSource;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       MemtoReg;
   logic       RegDst;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic       instr_done;
   logic       illegal_op;
   logic [3:0] state;
   modport master (
      input  op, mem_ready,
      output PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, instr_done, illegal_op, state
   );
   modport slave (
      output op, mem_ready,
      input  PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, instr_done, illegal_op, state
   );
endinterface

// File: rtl/multicycle_main_fsm_out_decode.sv
// multicycle_main_fsm_out_decode: Moore control word per state, gated by mem_ready in memory states
module multicycle_main_fsm_out_decode
   import multicycle_main_fsm_pkg::*;
(
   input  state_e     state_i,
   input  logic [5:0] op_i,
   input  logic       mem_ready_i,
   output ctrl_t      ctrl_o
);
   always_comb begin
      ctrl_o = '0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.mem_read  = 1'b1;
            ctrl_o.alu_src_b = SRCB_4;
            ctrl_o.ir_write  = mem_ready_i;
            ctrl_o.pc_write  = mem_ready_i;
         end
         S_DECODE: begin
            ctrl_o.alu_src_b  = SRCB_IMM2;
            ctrl_o.illegal_op = !is_legal_op(op_i);
            ctrl_o.instr_done = !is_legal_op(op_i);
         end
         S_MEMADR: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            ctrl_o.mem_read = 1'b1;
            ctrl_o.iord     = 1'b1;
         end
         S_MEMWB: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         S_MEMWR: begin
            ctrl_o.mem_write  = 1'b1;
            ctrl_o.iord       = 1'b1;
            ctrl_o.instr_done = mem_ready_i;
         end
         S_EXEC: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_op    = ALUOP_FUNCT;
         end
         S_RWB: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.reg_dst    = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         S_BRANCH: begin
            ctrl_o.alu_src_a     = 1'b1;
            ctrl_o.alu_op        = ALUOP_SUB;
            ctrl_o.pc_write_cond = 1'b1;
            ctrl_o.pc_source     = PCSRC_ALUOUT;
            ctrl_o.instr_done    = 1'b1;
         end
         S_JUMP: begin
            ctrl_o.pc_write   = 1'b1;
            ctrl_o.pc_source  = PCSRC_JUMP;
            ctrl_o.instr_done = 1'b1;
         end
         // unreachable encodings: FETCH selects, no enables
         default: ctrl_o.alu_src_b = SRCB_4;
      endcase
   end
endmodule

// File: rtl/multicycle_main_fsm.sv
// multicycle_main_fsm: main sequencing FSM of the multicycle MIPS datapath
module multicycle_main_fsm
   import multicycle_main_fsm_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   multicycle_main_fsm_if.master ctl_if
);
   state_e state_q, state_d;
   ctrl_t  ctrl_raw, ctrl;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= S_FETCH;
      else state_q <= state_d;
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = ctl_if.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: state_d = ctl_if.op inside {OP_LW, OP_SW} ? S_MEMADR :
                             ctl_if.op == OP_RTYPE ? S_EXEC :
                             ctl_if.op == OP_BEQ ? S_BRANCH :
                             ctl_if.op == OP_J ? S_JUMP : S_FETCH;
         S_MEMADR: state_d = ctl_if.op == OP_LW ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = ctl_if.mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:  state_d = ctl_if.mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   state_d = S_RWB;
         default:  state_d = S_FETCH;
      endcase
   end
   multicycle_main_fsm_out_decode u_dec (
      .state_i     (state_q),
      .op_i        (ctl_if.op),
      .mem_ready_i (ctl_if.mem_ready),
      .ctrl_o      (ctrl_raw)
   );
   // outputs are forced quiet while reset is held, not just after the state clears
   assign ctrl                = rst_n ? ctrl_raw : '0;
   assign ctl_if.PCWrite      = ctrl.pc_write;
   assign ctl_if.PCWriteCond  = ctrl.pc_write_cond;
   assign ctl_if.PCSource     = ctrl.pc_source;
   assign ctl_if.IorD         = ctrl.iord;
   assign ctl_if.MemRead      = ctrl.mem_read;
   assign ctl_if.MemWrite     = ctrl.mem_write;
   assign ctl_if.IRWrite      = ctrl.ir_write;
   assign ctl_if.MemtoReg     = ctrl.mem_to_reg;
   assign ctl_if.RegDst       = ctrl.reg_dst;
   assign ctl_if.RegWrite     = ctrl.reg_write;
   assign ctl_if.ALUSrcA      = ctrl.alu_src_a;
   assign ctl_if.ALUSrcB      = ctrl.alu_src_b;
   assign ctl_if.ALUOp        = ctrl.alu_op;
   assign ctl_if.instr_done   = ctrl.instr_done;
   assign ctl_if.illegal_op   = ctrl.illegal_op;
   assign ctl_if.state        = state_q;
endmodule

// File: tb/tb_multicycle_main_fsm.sv
// tb_multicycle_main_fsm: per-instruction plan model with random mem_ready stalls and random opcodes
module tb_multicycle_main_fsm;
   localparam logic [5:0] RT = 6'h00, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04, JMP = 6'h02;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   multicycle_main_fsm_if bus ();
   multicycle_main_fsm dut (.clk(clk), .rst_n(rst_n), .ctl_if(bus));
   always #5 clk = ~clk;
   logic [17:0] outs;
   assign outs = {bus.PCWrite, bus.PCWriteCond, bus.PCSource, bus.IorD, bus.MemRead, bus.MemWrite,
                  bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
                  bus.ALUOp, bus.instr_done, bus.illegal_op};
   // expected control outputs written straight from the per-state output table
   function automatic logic [17:0] exp_out(input int st, input bit rdy, input logic [5:0] op);
      logic pcw = 0, pcc = 0, iord = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rd = 0, rw = 0, sa = 0, done = 0, ill = 0;
      logic [1:0] pcs = 0, sb = 0, aop = 0;
      bit legal = (op == RT) || (op == LW) || (op == SW) || (op == BEQ) || (op == JMP);
      if (st == 0) begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      if (st == 1) begin sb = 2'b11; ill = !legal; done = !legal; end
      if (st == 2) begin sa = 1; sb = 2'b10; end
      if (st == 3) begin mr = 1; iord = 1; end
      if (st == 4) begin rw = 1; m2r = 1; done = 1; end
      if (st == 5) begin mw = 1; iord = 1; done = rdy; end
      if (st == 6) begin sa = 1; aop = 2'b10; end
      if (st == 7) begin rw = 1; rd = 1; done = 1; end
      if (st == 8) begin sa = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; done = 1; end
      if (st == 9) begin pcw = 1; pcs = 2'b10; done = 1; end
      return {pcw, pcc, pcs, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop, done, ill};
   endfunction
   // sf/sm: forced wait cycles in FETCH / data-memory step; rnd: random waits instead
   task automatic run_instr(input logic [5:0] op, input int sf, input int sm, input bit rnd);
      int plan[$];
      int i = 0, waits = 0, done_n = 0, ill_n = 0;
      bit rdy, mem;
      logic [17:0] e;
      plan = '{0, 1};
      if (op == RT) plan = '{0, 1, 6, 7};
      if (op == LW) plan = '{0, 1, 2, 3, 4};
      if (op == SW) plan = '{0, 1, 2, 5};
      if (op == BEQ) plan = '{0, 1, 8};
      if (op == JMP) plan = '{0, 1, 9};
      bus.op = op;
      while (i < plan.size()) begin
         mem = (plan[i] == 0) || (plan[i] == 3) || (plan[i] == 5);
         if (!mem) rdy = 1'($urandom_range(0, 1));
         else if (rnd) rdy = ($urandom_range(0, 2) != 0) || (waits >= 3);
         else rdy = waits >= ((plan[i] == 0) ? sf : sm);
         bus.mem_ready = rdy;
         #1;
         checks++;
         if (bus.state !== 4'(plan[i])) begin
            errors++;
            $display("FAIL state op=%h step=%0d: got %0d want %0d", op, i, bus.state, plan[i]);
         end
         e = exp_out(plan[i], rdy, op);
         checks++;
         if (outs !== e) begin
            errors++;
            $display("FAIL outputs op=%h state=%0d rdy=%0b: got %b want %b", op, plan[i], rdy, outs, e);
         end
         checks++;
         if ((bus.PCWrite && bus.PCWriteCond) || (bus.MemRead && bus.MemWrite)) begin
            errors++;
            $display("FAIL exclusive op=%h: got pcw/pcc/mr/mw=%b%b%b%b want no pair both 1",
                     op, bus.PCWrite, bus.PCWriteCond, bus.MemRead, bus.MemWrite);
         end
         if (bus.instr_done) done_n++;
         if (bus.illegal_op) ill_n++;
         if (mem && !rdy) waits++;
         else begin waits = 0; i++; end
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (done_n !== 1) begin
         errors++;
         $display("FAIL done_count op=%h: got %0d want 1", op, done_n);
      end
      checks++;
      if (ill_n !== ((plan.size() == 2) ? 1 : 0)) begin
         errors++;
         $display("FAIL illegal_count op=%h: got %0d want %0d", op, ill_n, (plan.size() == 2) ? 1 : 0);
      end
   endtask
   task automatic test_reset;
      bus.op = RT;
      bus.mem_ready = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (bus.state !== 4'd0 || outs !== 18'd0) begin
         errors++;
         $display("FAIL reset_hold: got state=%0d outs=%b want 0 / all zero", bus.state, outs);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus.state !== 4'd0 || outs !== exp_out(0, 1, RT)) begin
         errors++;
         $display("FAIL reset_release: got state=%0d outs=%b want 0 / %b", bus.state, outs, exp_out(0, 1, RT));
      end
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   task automatic test_reset_mid;
      bus.op = LW;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (bus.state !== 4'd3 || !bus.MemRead || !bus.IorD) begin
         errors++;
         $display("FAIL reset_mid_pre: got state=%0d mr=%b iord=%b want 3 1 1", bus.state, bus.MemRead, bus.IorD);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.state !== 4'd0 || outs !== 18'd0) begin
         errors++;
         $display("FAIL reset_mid_async: got state=%0d outs=%b want 0 / all zero", bus.state, outs);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus.mem_ready = 1'b1;
      #1;
      checks++;
      if (bus.state !== 4'd0 || outs !== exp_out(0, 1, LW)) begin
         errors++;
         $display("FAIL reset_mid_release: got state=%0d outs=%b want 0 / %b", bus.state, outs, exp_out(0, 1, LW));
      end
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   task automatic test_rtype;       run_instr(RT, 0, 0, 0); endtask
   task automatic test_lw_stall;    run_instr(LW, 0, 2, 0); endtask
   task automatic test_sw_stall;    run_instr(SW, 1, 0, 0); endtask
   task automatic test_branch_jump; run_instr(BEQ, 0, 0, 0); run_instr(JMP, 0, 0, 0); endtask
   task automatic test_illegal;     run_instr(6'h3F, 0, 0, 0); endtask
   task automatic test_back_to_back;
      logic [5:0] ops [6] = '{RT, LW, SW, BEQ, JMP, 6'h3F};
      for (int n = 0; n < 40; n++) begin
         int k = $urandom_range(0, 6);
         run_instr(k == 6 ? 6'($urandom_range(0, 63)) : ops[k], 0, 0, 1);
      end
   endtask
   initial begin
      test_reset;
      test_rtype;
      test_lw_stall;
      test_sw_stall;
      test_branch_jump;
      test_illegal;
      test_reset_mid;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
